// File: rtl/reuleaux_pkg.sv
// Shared types and constants for the Reuleaux triangle outline drawer.
package reuleaux_pkg;

  typedef enum logic [3:0] {
    IDLE,
    COMMENCE,
    O2,
    O3,
    O5,
    O6,
    O8,
    O7,
    DONE
  } state_e;

  typedef logic signed [9:0] coord_t;

  localparam int SCR_W       = 160;
  localparam int SCR_H       = 120;
  localparam int SQRT3_HALF  = 37;   // sqrt(3)/6 * 128 (centroid to base)
  localparam int SQRT3_THIRD = 74;   // sqrt(3)/3 * 128 (centroid to apex)
  localparam int SQRT3_SHIFT = 7;

endpackage

// File: rtl/reuleaux_bresenham.sv
// Midpoint circle stepper: holds ox/oy/crit, loads on init, advances on step,
// and flags when the step about to be taken ends the octant sweep.
module reuleaux_bresenham
  import reuleaux_pkg::*;
(
  input  logic       clk,
  input  logic       init,
  input  logic       step,
  input  logic [7:0] diameter,
  output coord_t     ox,
  output coord_t     oy,
  output logic       last
);

  coord_t             ox_q, ox_d, oy_q, oy_d, ox_s, oy_s;
  logic signed [11:0] crit_q, crit_d, crit_s;
  logic signed [11:0] oy_x, diff_x;

  // Candidate next values are always computed so the FSM can see the loop end.
  always_comb begin
    oy_s   = oy_q + 10'sd1;
    oy_x   = {{2{oy_s[9]}}, oy_s};
    ox_s   = ox_q;
    diff_x = '0;
    crit_s = crit_q;
    if (crit_q <= 12'sd0) begin
      crit_s = crit_q + (oy_x <<< 1) + 12'sd1;
    end else begin
      ox_s   = ox_q - 10'sd1;
      diff_x = oy_x - {{2{ox_s[9]}}, ox_s};
      crit_s = crit_q + (diff_x <<< 1) + 12'sd1;
    end
  end

  always_comb begin
    ox_d   = ox_q;
    oy_d   = oy_q;
    crit_d = crit_q;
    if (init) begin
      ox_d   = signed'({2'b00, diameter});
      oy_d   = '0;
      crit_d = 12'sd1 - signed'({4'b0000, diameter});
    end else if (step) begin
      ox_d   = ox_s;
      oy_d   = oy_s;
      crit_d = crit_s;
    end
  end

  always_ff @(posedge clk) begin
    ox_q   <= ox_d;
    oy_q   <= oy_d;
    crit_q <= crit_d;
  end

  assign ox   = ox_q;
  assign oy   = oy_q;
  assign last = (oy_s > ox_s);

endmodule

// File: rtl/reuleaux.sv
// Reuleaux triangle outline drawer: six clipped circle octants per Bresenham step.
// Define REULEAUX_CLIP_EN to suppress off-screen pixels instead of wrapping them.
module reuleaux
  import reuleaux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] diameter,
  input  logic       start,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  state_e      state_q, state_d;
  coord_t      ox, oy;
  logic        last;
  logic [14:0] d37, d74;
  coord_t      cx, cy, half_d, off_base, off_apex;
  coord_t      cx1_q, cx1_d, cx2_q, cx2_d, cx3_q, cx3_d, cy1_q, cy1_d, cy3_q, cy3_d;
  coord_t      x_tot, y_tot;
  logic        ok;
  logic        done_d, plot_d;
  logic [7:0]  x_d;
  logic [6:0]  y_d;

  reuleaux_bresenham u_bres (
    .clk      (clk),
    .init     (state_q == COMMENCE),
    .step     (state_q == O7),
    .diameter (diameter),
    .ox       (ox),
    .oy       (oy),
    .last     (last)
  );

  assign d37      = 15'(diameter) * 15'(SQRT3_HALF);
  assign d74      = 15'(diameter) * 15'(SQRT3_THIRD);
  assign cx       = signed'({2'b00, centre_x});
  assign cy       = signed'({3'b000, centre_y});
  assign half_d   = signed'({3'b000, diameter[7:1]});
  assign off_base = signed'({2'b00, d37[14:SQRT3_SHIFT]});
  assign off_apex = signed'({2'b00, d74[14:SQRT3_SHIFT]});

  always_comb begin
    cx1_d = cx1_q;
    cx2_d = cx2_q;
    cx3_d = cx3_q;
    cy1_d = cy1_q;
    cy3_d = cy3_q;
    if (state_q == COMMENCE) begin
      cx1_d = cx + half_d;
      cx2_d = cx - half_d;
      cx3_d = cx;
      cy1_d = cy + off_base;
      cy3_d = cy - off_apex;
    end
  end

  always_ff @(posedge clk) begin
    cx1_q <= cx1_d;
    cx2_q <= cx2_d;
    cx3_q <= cx3_d;
    cy1_q <= cy1_d;
    cy3_q <= cy3_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = COMMENCE;
      COMMENCE: state_d = O2;
      O2:       state_d = O3;
      O3:       state_d = O5;
      O5:       state_d = O6;
      O6:       state_d = O8;
      O8:       state_d = O7;
      O7:       state_d = last ? DONE : O2;
      DONE:     if (!start) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Each octant mirrors the arc about its corner; the guard keeps it inside the triangle.
  always_comb begin
    x_tot = '0;
    y_tot = '0;
    ok    = 1'b0;
    unique case (state_q)
      O2: begin x_tot = cx3_q + oy; y_tot = cy3_q + ox; ok = (x_tot <= cx1_q); end
      O3: begin x_tot = cx3_q - oy; y_tot = cy3_q + ox; ok = (x_tot >= cx2_q); end
      O5: begin x_tot = cx1_q - ox; y_tot = cy1_q - oy; ok = 1'b1;             end
      O6: begin x_tot = cx1_q - oy; y_tot = cy1_q - ox; ok = (x_tot <= cx3_q); end
      O8: begin x_tot = cx2_q + ox; y_tot = cy1_q - oy; ok = 1'b1;             end
      O7: begin x_tot = cx2_q + oy; y_tot = cy1_q - ox; ok = (x_tot >= cx3_q); end
      default: ok = 1'b0;
    endcase
`ifdef REULEAUX_CLIP_EN
    if (x_tot < 10'sd0 || x_tot >= coord_t'(SCR_W) ||
        y_tot < 10'sd0 || y_tot >= coord_t'(SCR_H)) ok = 1'b0;
`endif
  end

  always_comb begin
    plot_d = ok;
    x_d    = ok ? x_tot[7:0] : 8'd0;
    y_d    = ok ? y_tot[6:0] : 7'd0;
    done_d = (state_q == DONE) && start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      vga_x    <= '0;
      vga_y    <= '0;
      vga_plot <= 1'b0;
    end else begin
      done     <= done_d;
      vga_x    <= x_d;
      vga_y    <= y_d;
      vga_plot <= plot_d;
    end
  end

  assign vga_colour = colour;

endmodule

// File: tb/tb_reuleaux.sv
// Directed bench for reuleaux: fixed vectors plus a per-cycle arc model.
module tb_reuleaux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] colour = 3'b001;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] diameter = '0;
  logic       start = 1'b0;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reuleaux dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .colour     (colour),
    .centre_x   (centre_x),
    .centre_y   (centre_y),
    .diameter   (diameter),
    .start      (start),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    colour   = 3'b001;
    centre_x = 8'd80;
    centre_y = 7'd60;
    diameter = 8'd80;
    start    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (done !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0 || vga_plot !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: got done=%b x=%0d y=%0d plot=%b want 0 0 0 0",
                 i, done, vga_x, vga_y, vga_plot);
      end
    end
  endtask

  task automatic test_first_pixels();
    int ex[6] = '{80, 80, 40, 0, 120, 0};
    int ey[6] = '{94, 94, 83, 0, 83, 0};
    int ep[6] = '{1, 1, 1, 0, 1, 0};
    start = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (vga_x !== 8'(ex[i]) || vga_y !== 7'(ey[i]) || vga_plot !== 1'(ep[i]) ||
          vga_colour !== 3'b001) begin
        bad++;
        $display("FAIL first_pixel%0d: got (%0d,%0d,%b) col=%b want (%0d,%0d,%0d) col=001",
                 i, vga_x, vga_y, vga_plot, vga_colour, ex[i], ey[i], ep[i]);
      end
    end
  endtask

  // Called while a draw is in progress: async reset must clear outputs without a clock edge.
  task automatic test_reset_mid_draw();
    for (int i = 0; i < 7; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (done !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0 || vga_plot !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_draw: got done=%b x=%0d y=%0d plot=%b want 0 0 0 0",
               done, vga_x, vga_y, vga_plot);
    end
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if (done !== 1'b0 || vga_plot !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle: got done=%b plot=%b want 0 0", done, vga_plot);
    end
  endtask

  task automatic test_draw(input int cx, input int cy, input int d, input bit hold,
                           input string name);
    int cx1, cx2, cx3, cy1, cy3;
    int ox, oy, crit, x, y, passes;
    bit ok, finished;
    logic [7:0] ex;
    logic [6:0] ey;
    cx1 = cx + d / 2;
    cx2 = cx - d / 2;
    cx3 = cx;
    cy1 = cy + (d * 37) / 128;
    cy3 = cy - (d * 74) / 128;
    ox = d;
    oy = 0;
    crit = 1 - d;
    finished = 1'b0;
    passes = 0;
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    diameter = 8'(d);
    start = 1'b1;
    tick();
    tick();
    while (!finished && passes < 400) begin
      for (int k = 0; k < 6; k++) begin
        x = 0;
        y = 0;
        ok = 1'b0;
        case (k)
          0: begin x = cx3 + oy; y = cy3 + ox; ok = (x <= cx1); end
          1: begin x = cx3 - oy; y = cy3 + ox; ok = (x >= cx2); end
          2: begin x = cx1 - ox; y = cy1 - oy; ok = 1'b1;       end
          3: begin x = cx1 - oy; y = cy1 - ox; ok = (x <= cx3); end
          4: begin x = cx2 + ox; y = cy1 - oy; ok = 1'b1;       end
          default: begin x = cx2 + oy; y = cy1 - ox; ok = (x >= cx3); end
        endcase
`ifdef REULEAUX_CLIP_EN
        if (x < 0 || x >= 160 || y < 0 || y >= 120) ok = 1'b0;
`endif
        ex = ok ? 8'(x) : 8'd0;
        ey = ok ? 7'(y) : 7'd0;
        tick();
        if (!hold) start = 1'b0;
        total++;
        if (vga_x !== ex || vga_y !== ey || vga_plot !== ok || vga_colour !== colour ||
            done !== 1'b0) begin
          bad++;
          $display("FAIL %s pass%0d oct%0d: got (%0d,%0d,%b) col=%b done=%b want (%0d,%0d,%b) col=%b done=0",
                   name, passes, k, vga_x, vga_y, vga_plot, vga_colour, done, ex, ey, ok, colour);
        end
      end
      oy = oy + 1;
      if (crit <= 0) begin
        crit = crit + 2 * oy + 1;
      end else begin
        ox = ox - 1;
        crit = crit + 2 * (oy - ox) + 1;
      end
      if (oy > ox) finished = 1'b1;
      passes++;
    end
    tick();
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (done !== 1'b1 || vga_plot !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0) begin
          bad++;
          $display("FAIL %s done_hold%0d: got done=%b plot=%b x=%0d y=%0d want 1 0 0 0",
                   name, i, done, vga_plot, vga_x, vga_y);
        end
        tick();
      end
      start = 1'b0;
      tick();
    end
    tick();
    total++;
    if (done !== 1'b0 || vga_plot !== 1'b0) begin
      bad++;
      $display("FAIL %s back_to_idle: got done=%b plot=%b want 0 0", name, done, vga_plot);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixels();
    test_reset_mid_draw();
    test_draw(80, 60, 80, 1'b1, "draw_d80");
    test_draw(20, 20, 40, 1'b1, "draw_d40");
    test_draw(50, 50, 0, 1'b1, "draw_d0");
    test_draw(10, 10, 80, 1'b1, "draw_edge");
    colour = 3'b110;
    test_draw(100, 70, 30, 1'b0, "draw_start_drop");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
